// File: rtl/tpg_gen.sv
// ---------------------------------------------------------------------------
// tpg_gen -- video test pattern generator
//
// Generates raster timing (DE / HSYNC / VSYNC / SOF) and a selectable test
// pattern from programmable horizontal and vertical timing words.
//
// Optional feature macro: TPG_SCROLL_EN
//   When defined, a per-frame horizontal scroll offset is applied to the
//   gray ramp (mode 2) and checkerboard (mode 4). When undefined, no scroll
//   register exists and xs == x.
//
// Parameters
//   DW        bits per colour component
//   TW        width of each timing field and of the h/v counters
//   GRID_LOG2 grid / checker cell size is 2^GRID_LOG2 pixels
//
// Ports
//   I_pxl_clk     pixel clock
//   I_rst_n       asynchronous active-low reset
//   I_en          generator enable
//   I_mode        pattern select (0 bars, 1 grid, 2 gray, 3 single colour,
//                 4 checker, 5-7 blue)
//   I_single_rgb  single colour {B,G,R} for mode 3
//   I_h_timing    {total, sync, bporch, res}, total in the MSBs
//   I_v_timing    {total, sync, bporch, res}, total in the MSBs
//   I_hs_pol      1 = active-high HSYNC
//   I_vs_pol      1 = active-high VSYNC
//   O_de          active video
//   O_hs / O_vs   syncs at the shadowed polarity
//   O_sof         one-cycle pulse on the first active pixel of a frame
//   O_data        pixel {B,G,R}, zero outside active video
//   O_frame_cnt   completed-frame count, wraps 0xFFFF -> 0
//   O_dbg_state   current controller state (IDLE=0, LOAD=1, RUN=2)
//
// Output handshake: there is no back-pressure. Every output is a plain
// registered signal valid each cycle; O_de qualifies O_data. All video
// outputs appear exactly two clocks after the counter state they describe.
// ---------------------------------------------------------------------------
module tpg_gen #(
    parameter int DW        = 8,
    parameter int TW        = 12,
    parameter int GRID_LOG2 = 5
) (
    input  logic            I_pxl_clk,
    input  logic            I_rst_n,
    input  logic            I_en,
    input  logic [2:0]      I_mode,
    input  logic [3*DW-1:0] I_single_rgb,
    input  logic [4*TW-1:0] I_h_timing,
    input  logic [4*TW-1:0] I_v_timing,
    input  logic            I_hs_pol,
    input  logic            I_vs_pol,
    output logic            O_de,
    output logic            O_hs,
    output logic            O_vs,
    output logic            O_sof,
    output logic [3*DW-1:0] O_data,
    output logic [15:0]     O_frame_cnt,
    output logic [1:0]      O_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Wide enough to hold sync + bporch + res without overflow.
    localparam int XW = TW + 2;

    localparam logic [DW-1:0] CMAX = '1;
    localparam logic [DW-1:0] CZRO = '0;

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (I_en) state_d = ST_LOAD;
            ST_LOAD: state_d = I_en ? ST_RUN : ST_IDLE;
            ST_RUN:  if (!I_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign O_dbg_state = state_q;

    // ------------------------------------------------------------------
    // Shadow configuration
    // ------------------------------------------------------------------
    logic [2:0]      mode_q;
    logic [3*DW-1:0] rgb_q;
    logic [4*TW-1:0] htim_q;
    logic [4*TW-1:0] vtim_q;
    logic            hpol_q;
    logic            vpol_q;
    // Set by the first LOAD; until then the syncs are held at 0 rather
    // than at the inactive level implied by a cleared polarity shadow.
    logic            loaded_q;

    logic [TW-1:0] h_res, h_bp, h_sync, h_tot;
    logic [TW-1:0] v_res, v_bp, v_sync, v_tot;

    assign h_res  = htim_q[TW-1:0];
    assign h_bp   = htim_q[2*TW-1:TW];
    assign h_sync = htim_q[3*TW-1:2*TW];
    assign h_tot  = htim_q[4*TW-1:3*TW];
    assign v_res  = vtim_q[TW-1:0];
    assign v_bp   = vtim_q[2*TW-1:TW];
    assign v_sync = vtim_q[3*TW-1:2*TW];
    assign v_tot  = vtim_q[4*TW-1:3*TW];

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [TW-1:0] h_q, h_d;
    logic [TW-1:0] v_q, v_d;
    logic [TW-1:0] h_last, v_last;
    logic          run;
    logic          h_wrap, v_wrap, frame_wrap;
    logic          load_shadow;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    assign run = (state_q == ST_RUN);

    // A total of 0 behaves as a total of 1 so the counters never stall.
    assign h_last = (h_tot == '0) ? '0 : h_tot - 1'b1;
    assign v_last = (v_tot == '0) ? '0 : v_tot - 1'b1;

    // >= rather than == keeps the counters safe if a reloaded total is
    // smaller than the current position.
    assign h_wrap     = (h_q >= h_last);
    assign v_wrap     = (v_q >= v_last);
    assign frame_wrap = run && h_wrap && v_wrap;

    assign load_shadow = (state_q == ST_LOAD) || frame_wrap;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run) begin
            h_d = '0;
            v_d = '0;
        end else if (h_wrap) begin
            h_d = '0;
            v_d = v_wrap ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    assign O_frame_cnt = frame_cnt_q;

    // ------------------------------------------------------------------
    // Timing decode (counter domain)
    // ------------------------------------------------------------------
    logic [XW-1:0] h_act_start, h_act_end;
    logic [XW-1:0] v_act_start, v_act_end;
    logic          h_in, v_in;
    logic [TW-1:0] x, y;
    logic [TW-1:0] xs;
    logic          de_c, hs_act, vs_act, sof_c;
    logic          hs_lvl, vs_lvl;

    assign h_act_start = XW'(h_sync) + XW'(h_bp);
    assign h_act_end   = h_act_start + XW'(h_res);
    assign v_act_start = XW'(v_sync) + XW'(v_bp);
    assign v_act_end   = v_act_start + XW'(v_res);

    assign h_in = (XW'(h_q) >= h_act_start) && (XW'(h_q) < h_act_end);
    assign v_in = (XW'(v_q) >= v_act_start) && (XW'(v_q) < v_act_end);

    // Only meaningful inside the active window; modulo arithmetic is fine.
    assign x = h_q - TW'(h_act_start);
    assign y = v_q - TW'(v_act_start);

    assign de_c   = run && h_in && v_in;
    assign hs_act = run && (h_q < h_sync);
    assign vs_act = run && (v_q < v_sync);
    assign sof_c  = de_c && (x == '0) && (y == '0);

    assign hs_lvl = loaded_q && (hpol_q ? hs_act : !hs_act);
    assign vs_lvl = loaded_q && (vpol_q ? vs_act : !vs_act);

    // ------------------------------------------------------------------
    // Horizontal scroll
    // ------------------------------------------------------------------
`ifdef TPG_SCROLL_EN
    logic [TW-1:0] scroll_q, scroll_d;
    logic [TW:0]   xs_sum;

    always_comb begin
        scroll_d = scroll_q;
        if (!run) begin
            scroll_d = '0;
        end else if (frame_wrap) begin
            // Wrap after hres-1; with hres == 0 the offset stays at 0.
            if (({1'b0, scroll_q} + 1'b1) >= {1'b0, h_res})
                scroll_d = '0;
            else
                scroll_d = scroll_q + 1'b1;
        end
    end

    assign xs_sum = {1'b0, x} + {1'b0, scroll_q};
    assign xs     = (xs_sum >= {1'b0, h_res}) ? TW'(xs_sum - {1'b0, h_res})
                                              : xs_sum[TW-1:0];
`else
    assign xs = x;
`endif

    // ------------------------------------------------------------------
    // Pattern generation
    // ------------------------------------------------------------------
    logic [TW-1:0]   bar_w;
    logic [TW+2:0]   bar_thr;
    logic [2:0]      bar_idx;
    logic            grid_on;
    logic            chk_on;
    logic [DW-1:0]   gray;
    logic [3*DW-1:0] pix_rgb;

    assign bar_w = h_res >> 3;

    // bar_idx = min(x / bar_w, 7) built from seven threshold compares. A
    // zero bar width passes every compare, giving blue across the line.
    always_comb begin
        bar_idx = 3'd0;
        bar_thr = '0;
        for (int k = 1; k < 8; k++) begin
            bar_thr = (TW+3)'(bar_w) * (TW+3)'(k);
            if ((TW+3)'(x) >= bar_thr) bar_idx = bar_idx + 3'd1;
        end
    end

    assign grid_on = (x[GRID_LOG2-1:0] == '0) || (x == h_res - 1'b1) ||
                     (y[GRID_LOG2-1:0] == '0) || (y == v_res - 1'b1);

    assign chk_on = (|((xs >> GRID_LOG2) & TW'(1))) ^ y[GRID_LOG2];
    assign gray   = DW'(xs);

    always_comb begin
        pix_rgb = '0;
        case (mode_q)
            3'd0: begin
                case (bar_idx)
                    3'd0:    pix_rgb = {CMAX, CMAX, CMAX};  // white
                    3'd1:    pix_rgb = {CZRO, CMAX, CMAX};  // yellow
                    3'd2:    pix_rgb = {CMAX, CMAX, CZRO};  // cyan
                    3'd3:    pix_rgb = {CZRO, CMAX, CZRO};  // green
                    3'd4:    pix_rgb = {CMAX, CZRO, CMAX};  // magenta
                    3'd5:    pix_rgb = {CZRO, CZRO, CMAX};  // red
                    3'd6:    pix_rgb = {CZRO, CZRO, CZRO};  // black
                    default: pix_rgb = {CMAX, CZRO, CZRO};  // blue
                endcase
            end
            3'd1:    pix_rgb = grid_on ? {CZRO, CZRO, CMAX} : '0;
            3'd2:    pix_rgb = {gray, gray, gray};
            3'd3:    pix_rgb = rgb_q;
            3'd4:    pix_rgb = chk_on ? {CMAX, CMAX, CMAX} : '0;
            default: pix_rgb = {CMAX, CZRO, CZRO};
        endcase
    end

    // ------------------------------------------------------------------
    // Two-stage output pipeline: stage 1 captures the decoded counter
    // state, stage 2 drives the ports.
    // ------------------------------------------------------------------
    logic            s1_de_q, s1_hs_q, s1_vs_q, s1_sof_q;
    logic [3*DW-1:0] s1_data_q;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            rgb_q       <= '0;
            htim_q      <= '0;
            vtim_q      <= '0;
            hpol_q      <= 1'b0;
            vpol_q      <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            frame_cnt_q <= frame_cnt_d;
            if (load_shadow) begin
                mode_q <= I_mode;
                rgb_q  <= I_single_rgb;
                htim_q <= I_h_timing;
                vtim_q <= I_v_timing;
                hpol_q <= I_hs_pol;
                vpol_q <= I_vs_pol;
            end
            if (state_q == ST_LOAD) loaded_q <= 1'b1;
        end
    end

`ifdef TPG_SCROLL_EN
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) scroll_q <= '0;
        else          scroll_q <= scroll_d;
    end
`endif

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            s1_de_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_data_q <= '0;
            O_de      <= 1'b0;
            O_hs      <= 1'b0;
            O_vs      <= 1'b0;
            O_sof     <= 1'b0;
            O_data    <= '0;
        end else begin
            s1_de_q   <= de_c;
            s1_hs_q   <= hs_lvl;
            s1_vs_q   <= vs_lvl;
            s1_sof_q  <= sof_c;
            s1_data_q <= de_c ? pix_rgb : '0;
            O_de      <= s1_de_q;
            O_hs      <= s1_hs_q;
            O_vs      <= s1_vs_q;
            O_sof     <= s1_sof_q;
            O_data    <= s1_data_q;
        end
    end

endmodule

// File: tb/tb_tpg_gen.sv
// ---------------------------------------------------------------------------
// tb_tpg_gen -- self-checking bench for tpg_gen
//
// Uses a 20x6 raster (h={20,2,3,8}, v={6,1,1,3}) so one frame is 120 clocks.
// A small behavioural model produces the expected {de,hs,vs,sof,data} for
// every frame position; these are queued when a frame is started and
// popped one per clock while the DUT output is sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tpg_gen;

    localparam int DW    = 8;
    localparam int TW    = 12;
    localparam int GL2   = 2;
    localparam int OW    = 4 + 3*DW;
    localparam int H_TOT = 20;
    localparam int V_TOT = 6;
    localparam int FRAME = H_TOT * V_TOT;
`ifdef TPG_SCROLL_EN
    localparam int SCR = 1;
`else
    localparam int SCR = 0;
`endif

    logic            clk;
    logic            I_rst_n;
    logic            I_en;
    logic [2:0]      I_mode;
    logic [3*DW-1:0] I_single_rgb;
    logic [4*TW-1:0] I_h_timing;
    logic [4*TW-1:0] I_v_timing;
    logic            I_hs_pol;
    logic            I_vs_pol;
    logic            O_de, O_hs, O_vs, O_sof;
    logic [3*DW-1:0] O_data;
    logic [15:0]     O_frame_cnt;
    logic [1:0]      O_dbg_state;

    tpg_gen #(.DW(DW), .TW(TW), .GRID_LOG2(GL2)) dut (
        .I_pxl_clk    (clk),
        .I_rst_n      (I_rst_n),
        .I_en         (I_en),
        .I_mode       (I_mode),
        .I_single_rgb (I_single_rgb),
        .I_h_timing   (I_h_timing),
        .I_v_timing   (I_v_timing),
        .I_hs_pol     (I_hs_pol),
        .I_vs_pol     (I_vs_pol),
        .O_de         (O_de),
        .O_hs         (O_hs),
        .O_vs         (O_vs),
        .O_sof        (O_sof),
        .O_data       (O_data),
        .O_frame_cnt  (O_frame_cnt),
        .O_dbg_state  (O_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_frames = 0;
    int            pos_i, de_seen, sof_seen;
    logic [23:0]   first_pix;
    logic          first_got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural expectation for frame position p with scroll offset s.
    function automatic logic [OW-1:0] exp_out(input logic [2:0] mode, input logic [23:0] rgb,
                                              input logic hp, input logic vp,
                                              input int p, input int s);
        int h, v, x, y, xs;
        logic de, sof;
        logic [7:0]  g;
        logic [23:0] c;
        h  = p % H_TOT;
        v  = p / H_TOT;
        x  = h - 5;
        y  = v - 2;
        de = (h >= 5) && (h < 13) && (v >= 2) && (v < 5);
        sof = de && (x == 0) && (y == 0);
        xs = (x + s) % 8;
        g  = 8'(xs);
        c  = 24'h0;
        case (mode)
            3'd0: begin
                case ((x > 7) ? 7 : x)
                    0: c = 24'hFFFFFF;
                    1: c = 24'h00FFFF;
                    2: c = 24'hFFFF00;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'h0000FF;
                    6: c = 24'h000000;
                    default: c = 24'hFF0000;
                endcase
            end
            3'd1: c = ((x % 4 == 0) || (x == 7) || (y % 4 == 0) || (y == 2)) ? 24'h0000FF : 24'h0;
            3'd2: c = {g, g, g};
            3'd3: c = rgb;
            3'd4: c = (((xs / 4) % 2) != ((y / 4) % 2)) ? 24'hFFFFFF : 24'h0;
            default: c = 24'hFF0000;
        endcase
        return {de, (h < 2) == hp, (v < 1) == vp, sof, de ? c : 24'h0};
    endfunction

    task automatic push_frame(input logic [2:0] mode, input logic [23:0] rgb,
                              input logic hp, input logic vp, input int s);
        for (int p = 0; p < FRAME; p++) exp_q.push_back(exp_out(mode, rgb, hp, vp, p, s));
    endtask

    // Raise enable and advance to the clock just before frame position 0.
    task automatic start_gen();
        @(negedge clk);
        I_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("state_run", 64'(O_dbg_state), 64'd2);
        pos_i = 0; de_seen = 0; sof_seen = 0; first_got = 1'b0; first_pix = '0;
    endtask

    task automatic check_positions(input int n);
        logic [OW-1:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_underflow at p=%0d", pos_i);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("pix p=%0d", pos_i),
                    64'({O_de, O_hs, O_vs, O_sof, O_data}), 64'(e));
            end
            if (O_de) begin
                de_seen++;
                if (!first_got) begin first_pix = O_data; first_got = 1'b1; end
            end
            if (O_sof) sof_seen++;
            pos_i++;
        end
    endtask

    task automatic stop_gen(input logic hp, input logic vp);
        I_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_out", 64'({O_de, O_hs, O_vs, O_sof, O_data}),
            64'({1'b0, !hp, !vp, 1'b0, 24'h0}));
        chk("idle_state", 64'(O_dbg_state), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  mode;
        logic [23:0] rgb;
        logic        hp;
        logic        vp;
        int          exp_de;
        int          exp_sof;
        logic [23:0] exp_first;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3'd0, 24'h000000, 1'b1, 1'b1, 24, 1, 24'hFFFFFF};
        tbl[1] = '{3'd1, 24'h000000, 1'b1, 1'b1, 24, 1, 24'h0000FF};
        tbl[2] = '{3'd2, 24'h000000, 1'b1, 1'b0, 24, 1, 24'h000000};
        tbl[3] = '{3'd3, 24'h123456, 1'b0, 1'b0, 24, 1, 24'h123456};
        tbl[4] = '{3'd4, 24'h000000, 1'b1, 1'b1, 24, 1, 24'h000000};
        tbl[5] = '{3'd5, 24'h00FF00, 1'b0, 1'b1, 24, 1, 24'hFF0000};
        tbl[6] = '{3'd7, 24'h00FF00, 1'b1, 1'b1, 24, 1, 24'hFF0000};
        tbl[7] = '{3'd0, 24'h000000, 1'b0, 1'b0, 24, 1, 24'hFFFFFF};

        I_rst_n      = 1'b1;
        I_en         = 1'b0;
        I_mode       = 3'd0;
        I_single_rgb = '0;
        I_h_timing   = {12'd20, 12'd2, 12'd3, 12'd8};
        I_v_timing   = {12'd6, 12'd1, 12'd1, 12'd3};
        I_hs_pol     = 1'b1;
        I_vs_pol     = 1'b1;
        #2 I_rst_n   = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_out", 64'({O_de, O_hs, O_vs, O_sof, O_data}), 64'd0);
        chk("rst_fcnt", 64'(O_frame_cnt), 64'd0);
        chk("rst_state", 64'(O_dbg_state), 64'd0);
        I_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_load_syncs", 64'({O_hs, O_vs}), 64'd0);

        // ---- table-driven single frames ----
        for (int t = 0; t < 8; t++) begin
            I_mode       = tbl[t].mode;
            I_single_rgb = tbl[t].rgb;
            I_hs_pol     = tbl[t].hp;
            I_vs_pol     = tbl[t].vp;
            push_frame(tbl[t].mode, tbl[t].rgb, tbl[t].hp, tbl[t].vp, 0);
            start_gen();
            check_positions(FRAME);
            chk($sformatf("de_cnt v%0d", t), 64'(de_seen), 64'(tbl[t].exp_de));
            chk($sformatf("sof_cnt v%0d", t), 64'(sof_seen), 64'(tbl[t].exp_sof));
            chk($sformatf("first_pix v%0d", t), 64'(first_pix), 64'(tbl[t].exp_first));
            stop_gen(tbl[t].hp, tbl[t].vp);
            exp_frames++;
            chk($sformatf("fcnt v%0d", t), 64'(O_frame_cnt), 64'(exp_frames));
        end

        // ---- mode change mid-frame: 3 -> 2 takes effect next frame ----
        I_mode = 3'd3; I_single_rgb = 24'hA5C3E1; I_hs_pol = 1'b1; I_vs_pol = 1'b1;
        push_frame(3'd3, 24'hA5C3E1, 1'b1, 1'b1, 0);
        push_frame(3'd2, 24'h0, 1'b1, 1'b1, SCR);
        start_gen();
        check_positions(30);
        I_mode = 3'd2; I_single_rgb = 24'h0F0F0F;
        check_positions(2*FRAME - 30);
        stop_gen(1'b1, 1'b1);
        exp_frames += 2;
        chk("fcnt_modechg", 64'(O_frame_cnt), 64'(exp_frames));

        // ---- enable dropped mid-line, restart from h=v=0 ----
        I_mode = 3'd0;
        push_frame(3'd0, 24'h0, 1'b1, 1'b1, 0);
        start_gen();
        check_positions(50);
        exp_q.delete();
        stop_gen(1'b1, 1'b1);
        repeat (7) @(negedge clk);
        chk("fcnt_abort", 64'(O_frame_cnt), 64'(exp_frames));
        push_frame(3'd0, 24'h0, 1'b1, 1'b1, 0);
        start_gen();
        check_positions(FRAME);
        chk("sof_restart", 64'(sof_seen), 64'd1);
        stop_gen(1'b1, 1'b1);
        exp_frames++;
        chk("fcnt_restart", 64'(O_frame_cnt), 64'(exp_frames));

        // ---- zero totals: every RUN cycle is a frame wrap, no de ----
        I_h_timing = '0;
        I_v_timing = '0;
        start_gen();
        chk("zero_fcnt_a", 64'(O_frame_cnt), 64'((exp_frames + 1) & 16'hFFFF));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (O_de) de_seen++;
        end
        chk("zero_de", 64'(de_seen), 64'd0);
        chk("zero_fcnt_b", 64'(O_frame_cnt), 64'((exp_frames + 11) & 16'hFFFF));
        stop_gen(1'b1, 1'b1);
        exp_frames += 12;
        chk("zero_fcnt_c", 64'(O_frame_cnt), 64'(exp_frames & 16'hFFFF));
        I_h_timing = {12'd20, 12'd2, 12'd3, 12'd8};
        I_v_timing = {12'd6, 12'd1, 12'd1, 12'd3};

`ifdef TPG_SCROLL_EN
        // ---- scrolled gray ramp over nine frames ----
        I_mode = 3'd2;
        for (int f = 0; f < 9; f++) push_frame(3'd2, 24'h0, 1'b1, 1'b1, f % 8);
        start_gen();
        check_positions(9*FRAME);
        stop_gen(1'b1, 1'b1);
        exp_frames += 9;
        chk("fcnt_scroll", 64'(O_frame_cnt), 64'(exp_frames & 16'hFFFF));
`endif

        // ---- reset asserted mid-frame ----
        I_mode = 3'd0;
        push_frame(3'd0, 24'h0, 1'b1, 1'b1, 0);
        start_gen();
        check_positions(40);
        exp_q.delete();
        I_rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 64'({O_de, O_hs, O_vs, O_sof, O_data}), 64'd0);
        chk("rst_mid_fcnt", 64'(O_frame_cnt), 64'd0);
        chk("rst_mid_state", 64'(O_dbg_state), 64'd0);
        I_en = 1'b0;
        repeat (2) @(negedge clk);
        I_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
